// File: rtl/tl_rx_cpl_tag_tracker.sv
// Per-tag outstanding-request scoreboard for non-posted TX requests; checks RX completions
// against it and reports unexpected completions, tag-reuse conflicts and a first-error log.
module tl_rx_cpl_tag_tracker #(
    parameter int unsigned REQUESTER_ID_WIDTH  = 16,
    parameter int unsigned REQUESTER_TAG_WIDTH = 10,
    parameter int unsigned ERR_CNT_WIDTH       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tx_req_valid,
    input  logic [REQUESTER_TAG_WIDTH-1:0] tx_req_tag,
    input  logic [REQUESTER_ID_WIDTH-1:0]  tx_req_id,
    input  logic                           rx_cpl_valid,
    input  logic [2:0]                     typ,
    input  logic [REQUESTER_ID_WIDTH-1:0]  rx_req_id,
    input  logic [REQUESTER_TAG_WIDTH-1:0] rx_req_tag,
    input  logic                           rx_cpl_last,
    input  logic                           uc_en,
    input  logic                           err_clr,
    output logic                           uc_error,
    output logic                           tx_tag_conflict,
    output logic                           tags_full,
    output logic [REQUESTER_TAG_WIDTH:0]   outstanding_cnt,
    output logic [ERR_CNT_WIDTH-1:0]       uc_err_cnt,
    output logic                           uc_log_valid,
    output logic [REQUESTER_TAG_WIDTH-1:0] uc_log_tag,
    output logic [REQUESTER_ID_WIDTH-1:0]  uc_log_id
);

    localparam int unsigned NUM_TAGS = 2 ** REQUESTER_TAG_WIDTH;
    localparam int unsigned CNT_W    = REQUESTER_TAG_WIDTH + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_TAGS);
    localparam logic [2:0] TYP_CPL = 3'b010;

    logic [NUM_TAGS-1:0]            busy_q, busy_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [ERR_CNT_WIDTH-1:0]       err_cnt_q, err_cnt_d;
    logic                           log_valid_q, log_valid_d;
    logic [REQUESTER_TAG_WIDTH-1:0] log_tag_q, log_tag_d;
    logic [REQUESTER_ID_WIDTH-1:0]  log_id_q, log_id_d;
    logic                           uc_error_q, uc_error_d;
    logic                           conflict_q, conflict_d;

    logic cpl_chk, cpl_expected, cpl_release, same_tag_release, alloc_ok, uc_fire;

    always_comb begin
        cpl_chk          = rx_cpl_valid && (typ == TYP_CPL);
        cpl_expected     = cpl_chk && (rx_req_id == tx_req_id) && busy_q[rx_req_tag];
        cpl_release      = cpl_expected && rx_cpl_last;
        same_tag_release = cpl_release && (rx_req_tag == tx_req_tag);
        // A tag freed by a final completion this cycle may be reallocated in the same cycle.
        alloc_ok         = tx_req_valid && (!busy_q[tx_req_tag] || same_tag_release);
        conflict_d       = tx_req_valid && !alloc_ok;
        uc_fire          = cpl_chk && !cpl_expected && uc_en;
        uc_error_d       = uc_fire;
    end

    always_comb begin
        busy_d = busy_q;
        if (cpl_release) begin
            busy_d[rx_req_tag] = 1'b0;
        end
        if (alloc_ok) begin
            busy_d[tx_req_tag] = 1'b1;
        end
        cnt_d = cnt_q + CNT_W'(alloc_ok) - CNT_W'(cpl_release);
    end

    always_comb begin
        err_cnt_d   = err_cnt_q;
        log_valid_d = log_valid_q;
        log_tag_d   = log_tag_q;
        log_id_d    = log_id_q;
        if (err_clr) begin
            err_cnt_d   = '0;
            log_valid_d = 1'b0;
        end
        if (uc_fire) begin
            if (err_clr) begin
                err_cnt_d = ERR_CNT_WIDTH'(1);
            end else if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
            end
            if (!log_valid_q || err_clr) begin
                log_valid_d = 1'b1;
                log_tag_d   = rx_req_tag;
                log_id_d    = rx_req_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            cnt_q       <= '0;
            err_cnt_q   <= '0;
            log_valid_q <= 1'b0;
            log_tag_q   <= '0;
            log_id_q    <= '0;
            uc_error_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            err_cnt_q   <= err_cnt_d;
            log_valid_q <= log_valid_d;
            log_tag_q   <= log_tag_d;
            log_id_q    <= log_id_d;
            uc_error_q  <= uc_error_d;
            conflict_q  <= conflict_d;
        end
    end

    assign uc_error        = uc_error_q;
    assign tx_tag_conflict = conflict_q;
    assign outstanding_cnt = cnt_q;
    assign tags_full       = (cnt_q == FULL_CNT);
    assign uc_err_cnt      = err_cnt_q;
    assign uc_log_valid    = log_valid_q;
    assign uc_log_tag      = log_tag_q;
    assign uc_log_id       = log_id_q;

endmodule

// File: tb/tb_tl_rx_cpl_tag_tracker.sv
// Bench for tl_rx_cpl_tag_tracker: directed scenarios plus random traffic, each cycle compared
// against an array-based reference model of the outstanding-tag rules.
module tb_tl_rx_cpl_tag_tracker;

    localparam int IDW = 16;
    localparam int TW  = 10;
    localparam int EW  = 8;
    localparam int NT  = 1 << TW;
    localparam int ERR_MAX = (1 << EW) - 1;
    localparam logic [IDW-1:0] TID = 16'hABCD;

    logic           clk = 1'b0;
    logic           rst;
    logic           tx_req_valid;
    logic [TW-1:0]  tx_req_tag;
    logic [IDW-1:0] tx_req_id;
    logic           rx_cpl_valid;
    logic [2:0]     typ;
    logic [IDW-1:0] rx_req_id;
    logic [TW-1:0]  rx_req_tag;
    logic           rx_cpl_last;
    logic           uc_en;
    logic           err_clr;
    logic           uc_error;
    logic           tx_tag_conflict;
    logic           tags_full;
    logic [TW:0]    outstanding_cnt;
    logic [EW-1:0]  uc_err_cnt;
    logic           uc_log_valid;
    logic [TW-1:0]  uc_log_tag;
    logic [IDW-1:0] uc_log_id;

    tl_rx_cpl_tag_tracker #(
        .REQUESTER_ID_WIDTH (IDW),
        .REQUESTER_TAG_WIDTH(TW),
        .ERR_CNT_WIDTH      (EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tx_req_valid   (tx_req_valid),
        .tx_req_tag     (tx_req_tag),
        .tx_req_id      (tx_req_id),
        .rx_cpl_valid   (rx_cpl_valid),
        .typ            (typ),
        .rx_req_id      (rx_req_id),
        .rx_req_tag     (rx_req_tag),
        .rx_cpl_last    (rx_cpl_last),
        .uc_en          (uc_en),
        .err_clr        (err_clr),
        .uc_error       (uc_error),
        .tx_tag_conflict(tx_tag_conflict),
        .tags_full      (tags_full),
        .outstanding_cnt(outstanding_cnt),
        .uc_err_cnt     (uc_err_cnt),
        .uc_log_valid   (uc_log_valid),
        .uc_log_tag     (uc_log_tag),
        .uc_log_id      (uc_log_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit m_busy [NT];
    int m_err;
    bit m_logv;
    int m_logtag;
    int m_logid;
    bit m_uce;
    bit m_conf;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < NT; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_update();
        bit is_cpl, expected, rel, alloc, fire;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_err = 0; m_logv = 0; m_logtag = 0; m_logid = 0; m_uce = 0; m_conf = 0;
            return;
        end
        is_cpl   = rx_cpl_valid && typ == 3'd2;
        expected = is_cpl && rx_req_id == tx_req_id && m_busy[rx_req_tag];
        rel      = expected && rx_cpl_last;
        alloc    = 1'b0;
        m_conf   = 1'b0;
        if (tx_req_valid) begin
            if (!m_busy[tx_req_tag] || (rel && rx_req_tag == tx_req_tag)) alloc = 1'b1;
            else m_conf = 1'b1;
        end
        if (rel) m_busy[rx_req_tag] = 1'b0;
        if (alloc) m_busy[tx_req_tag] = 1'b1;
        fire  = is_cpl && !expected && uc_en;
        m_uce = fire;
        if (err_clr) begin
            m_err  = 0;
            m_logv = 0;
        end
        if (fire) begin
            if (m_err < ERR_MAX) m_err++;
            if (!m_logv) begin
                m_logv   = 1;
                m_logtag = int'(rx_req_tag);
                m_logid  = int'(rx_req_id);
            end
        end
    endtask

    task automatic step();
        int pc;
        model_update();
        @(posedge clk);
        #1;
        pc = popcount();
        check("uc_error", 64'(uc_error), 64'(m_uce));
        check("tx_tag_conflict", 64'(tx_tag_conflict), 64'(m_conf));
        check("outstanding_cnt", 64'(outstanding_cnt), 64'(pc));
        check("tags_full", 64'(tags_full), 64'(pc == NT));
        check("uc_err_cnt", 64'(uc_err_cnt), 64'(m_err));
        check("uc_log_valid", 64'(uc_log_valid), 64'(m_logv));
        if (m_logv) begin
            check("uc_log_tag", 64'(uc_log_tag), 64'(m_logtag));
            check("uc_log_id", 64'(uc_log_id), 64'(m_logid));
        end
    endtask

    task automatic idle();
        rst = 0; tx_req_valid = 0; tx_req_tag = '0; tx_req_id = TID;
        rx_cpl_valid = 0; typ = 3'd0; rx_req_id = '0; rx_req_tag = '0;
        rx_cpl_last = 0; uc_en = 1; err_clr = 0;
    endtask

    task automatic set_alloc(input int tag);
        tx_req_valid = 1; tx_req_tag = TW'(tag);
    endtask

    task automatic set_cpl(input int tag, input logic [IDW-1:0] id, input bit last);
        rx_cpl_valid = 1; typ = 3'd2; rx_req_tag = TW'(tag); rx_req_id = id; rx_cpl_last = last;
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        step();
        check("reset_cnt", 64'(outstanding_cnt), 64'd0);

        // Allocate 5, then final completion next cycle
        idle(); set_alloc(5); step();
        check("alloc5_cnt", 64'(outstanding_cnt), 64'd1);
        idle(); set_cpl(5, TID, 1); step();
        check("rel5_cnt", 64'(outstanding_cnt), 64'd0);
        check("rel5_uc", 64'(uc_error), 64'd0);

        // Unexpected tag 7 with and without reporting
        idle(); set_cpl(7, TID, 1); step();
        check("uc7_cnt", 64'(uc_err_cnt), 64'd1);
        check("uc7_tag", 64'(uc_log_tag), 64'd7);
        idle(); step();
        idle(); uc_en = 0; set_cpl(7, TID, 1); step();
        check("uc7_dis", 64'(uc_error), 64'd0);

        // Split completion on tag 3, then stale and wrong-id completions
        idle(); set_alloc(3); step();
        idle(); set_cpl(3, TID, 0); step();
        idle(); set_cpl(3, TID, 1); step();
        idle(); set_cpl(3, TID, 1); step();
        check("stale3", 64'(uc_error), 64'd1);
        idle(); set_alloc(3); step();
        idle(); set_cpl(3, TID ^ 16'h1, 1); step();
        check("wrongid", 64'(uc_error), 64'd1);
        idle(); set_cpl(3, TID, 1); step();

        // Tag reuse conflict and same-cycle release + reallocate
        idle(); set_alloc(9); step();
        idle(); set_alloc(9); step();
        check("conf9", 64'(tx_tag_conflict), 64'd1);
        idle(); set_alloc(9); set_cpl(9, TID, 1); step();
        check("realloc9", 64'(tx_tag_conflict), 64'd0);
        check("realloc9_cnt", 64'(outstanding_cnt), 64'd1);
        // Unexpected completion on a free tag while allocating it
        idle(); set_alloc(11); set_cpl(11, TID, 1); step();
        // Non-CPL types are ignored
        idle(); set_cpl(20, TID, 1); typ = 3'd0; step();

        // Fill all tags
        for (int t = 0; t < NT; t++) begin
            idle(); set_alloc(t); step();
        end
        check("full", 64'(tags_full), 64'd1);
        check("full_cnt", 64'(outstanding_cnt), 64'(NT));
        idle(); set_cpl(100, TID, 1); step();
        check("not_full", 64'(tags_full), 64'd0);

        // Error count saturation and err_clr with simultaneous error
        idle(); rst = 1; step();
        for (int i = 0; i < (1 << EW) + 3; i++) begin
            idle(); set_cpl(200 + i, TID, 1); step();
        end
        check("sat", 64'(uc_err_cnt), 64'(ERR_MAX));
        check("sat_log", 64'(uc_log_tag), 64'd200);
        idle(); err_clr = 1; set_cpl(42, TID, 1); step();
        check("clr_cnt", 64'(uc_err_cnt), 64'd1);
        check("clr_log", 64'(uc_log_tag), 64'd42);

        // Reset mid-sequence overrides activity; earlier tags become unexpected
        idle(); set_alloc(1); step();
        idle(); rst = 1; set_alloc(2); set_cpl(1, TID, 1); step();
        check("rst_cnt", 64'(outstanding_cnt), 64'd0);
        idle(); set_cpl(1, TID, 1); step();
        check("rst_uc", 64'(uc_error), 64'd1);

        // Random traffic on a small tag window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            idle();
            rst          = ($urandom_range(0, 299) == 0);
            err_clr      = ($urandom_range(0, 49) == 0);
            uc_en        = ($urandom_range(0, 9) < 8);
            tx_req_valid = ($urandom_range(0, 1) == 1);
            tx_req_tag   = TW'($urandom_range(0, 15));
            rx_cpl_valid = ($urandom_range(0, 2) != 0);
            typ          = ($urandom_range(0, 7) < 6) ? 3'd2 : 3'($urandom_range(0, 4));
            rx_req_tag   = TW'($urandom_range(0, 15));
            rx_req_id    = ($urandom_range(0, 9) == 0) ? IDW'($urandom) : TID;
            rx_cpl_last  = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tl_rx_cpl_tag_tracker.md
# tl_rx_cpl_tag_tracker

Successor to the single-register unexpected-completion checker. It keeps a per-tag outstanding scoreboard of non-posted requests issued on the TX side. Each received completion is checked against that scoreboard, and the tag is released on the final completion. It reports unexpected completions, TX tag-reuse conflicts, an error count and a first-error log to the RX error-reporting logic in the write-handler error-check path.

## Interface
- REQUESTER_ID_WIDTH, 16, requester/completer ID width
- REQUESTER_TAG_WIDTH, 10, tag width; scoreboard depth NUM_TAGS = 2**REQUESTER_TAG_WIDTH
- ERR_CNT_WIDTH, 8, width of saturating error counter

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- tx_req_valid  in  1  non-posted request issued this cycle; allocates tx_req_tag
- tx_req_tag  in  REQUESTER_TAG_WIDTH  tag of issued request
- tx_req_id  in  REQUESTER_ID_WIDTH  own requester ID (quasi-static config)
- rx_cpl_valid  in  1  RX TLP header valid this cycle
- typ  in  3  TLP type: 000 MEM, 001 IO, 010 CPL, 011 CFG, 100 MSG
- rx_req_id  in  REQUESTER_ID_WIDTH  requester ID field of received completion
- rx_req_tag  in  REQUESTER_TAG_WIDTH  tag field of received completion
- rx_cpl_last  in  1  completion is the final one for its request (releases tag)
- uc_en  in  1  unexpected-completion reporting enable
- err_clr  in  1  clears error counter and error log
- uc_error  out  1  registered one-cycle pulse: unexpected completion detected
- tx_tag_conflict  out  1  registered one-cycle pulse: TX allocated an already-outstanding tag
- tags_full  out  1  all NUM_TAGS tags outstanding
- outstanding_cnt  out  REQUESTER_TAG_WIDTH+1  number of outstanding tags
- uc_err_cnt  out  ERR_CNT_WIDTH  saturating count of uc_error pulses
- uc_log_valid  out  1  first-error log holds data
- uc_log_tag  out  REQUESTER_TAG_WIDTH  tag of first logged unexpected completion
- uc_log_id  out  REQUESTER_ID_WIDTH  requester ID of first logged unexpected completion

## Operation
- Scoreboard: NUM_TAGS bit register `busy[]`. Reset clears all bits. All outputs reset to 0.
- Completion check: active only when rx_cpl_valid=1 and typ=010. Other types are ignored entirely.
- Expected: rx_req_id == tx_req_id and busy[rx_req_tag]=1, evaluated on pre-edge state.
- Expected completion with rx_cpl_last=1 clears busy[rx_req_tag]. With rx_cpl_last=0 there is no change (split completion).
- Unexpected: any CPL that is not expected. The scoreboard is never modified.
  - uc_en=1: pulse uc_error, increment uc_err_cnt (saturate at all-ones). If uc_log_valid=0, capture rx_req_tag/rx_req_id and set uc_log_valid.
  - uc_en=0: silently dropped. No pulse, no count, no log.
- TX allocate (tx_req_valid=1):
  - busy[tx_req_tag]=0: set the bit.
  - busy[tx_req_tag]=1: pulse tx_tag_conflict, bit unchanged, count unchanged. The only exception is the same-cycle release case below.
- Same-cycle, same tag, final expected completion plus allocate: release and reallocate. Bit stays 1, outstanding_cnt unchanged, no conflict.
- Same-cycle, different tags: both updates apply.
- Same-cycle, same tag, unexpected completion plus allocate on a free tag: completion flagged, allocation proceeds.
- outstanding_cnt: +1 on successful allocate, −1 on release, net 0 when both occur. Always equals popcount(busy). tags_full = (outstanding_cnt == NUM_TAGS).
- err_clr: clears uc_err_cnt and uc_log_valid. If an unexpected completion occurs in the same cycle, the result is count=1 and the log captures the new error.
- uc_log_tag/uc_log_id hold their values until the next capture. Their values are don't-care while uc_log_valid=0.

## Timing
- Latency 1 cycle: stimulus at edge N drives uc_error, tx_tag_conflict, counters, log and scoreboard after edge N+1.
- A completion checked in cycle N+1 sees updates from cycle N (back-to-back allocate then completion on the same tag is expected).
- No backpressure. Inputs are sampled every cycle with rx_cpl_valid/tx_req_valid as qualifiers.
- Reset is synchronous. rst=1 at an edge clears the scoreboard, counts, log and pulses regardless of other inputs, and overrides any simultaneous event.
- Reset in mid-sequence: completions for tags issued before reset are unexpected afterwards.

## Test plan
- Reset; allocate tag 5; CPL id=tx_req_id, tag 5, last=1 next cycle -> uc_error=0, outstanding_cnt 1→0, busy[5]=0.
- CPL tag 7 never allocated, uc_en=1 -> uc_error pulse one cycle, uc_err_cnt=1, uc_log_tag=7, uc_log_valid=1. Repeat with uc_en=0 -> no pulse, count stays 1.
- Allocate tag 3; split CPL last=0 then last=1 -> both expected, tag freed only after second. Third CPL tag 3 -> uc_error. Wrong rx_req_id on an allocated tag -> uc_error.
- Allocate tag 9 twice without release -> tx_tag_conflict on second, outstanding_cnt=1. Same-cycle final CPL tag 9 plus allocate 9 -> no conflict, cnt stays 1.
- Allocate all NUM_TAGS tags -> tags_full=1, outstanding_cnt=NUM_TAGS. Release one -> tags_full=0.
- Drive 2**ERR_CNT_WIDTH+3 unexpected CPLs -> uc_err_cnt saturates at all-ones, log still holds the first tag. err_clr together with an unexpected CPL -> cnt=1, log holds the new tag. rst mid-run -> all outputs 0 next cycle.
